// File: rtl/ptr_sync_pkg.sv
// Shared constants and Gray/binary helpers for the pointer synchronisers.
// Helpers take zero-extended values; a narrower pointer simply leaves its upper bits 0.
package ptr_sync_pkg;

    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_PTR_WIDTH   = 64;

    function automatic logic [MAX_PTR_WIDTH-1:0] gray2bin(input logic [MAX_PTR_WIDTH-1:0] gray);
        logic [MAX_PTR_WIDTH-1:0] bin;
        bin = gray;
        for (int i = MAX_PTR_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic logic [MAX_PTR_WIDTH-1:0] bin2gray(input logic [MAX_PTR_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic bit params_ok(input int bus_width, input int num_stages);
        return (bus_width >= 2) && (num_stages >= MIN_SYNC_STAGES);
    endfunction

endpackage

// File: rtl/ptr_sync_ch.sv
// One pointer channel: Gray flop chain, Gray-to-binary, and change/delta stage.
// PTR_SYNC_BIN_REG_EN adds a register after the conversion (one extra cycle on sync_bin/changed/delta).
module ptr_sync_ch
    import ptr_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_gray,
    output logic [BUS_WIDTH-1:0] sync_gray,
    output logic [BUS_WIDTH-1:0] sync_bin,
    output logic                 changed,
    output logic [BUS_WIDTH-1:0] delta
);

    if (!params_ok(BUS_WIDTH, NUM_STAGES)) begin : g_param_err
        $error("ptr_sync_ch: need BUS_WIDTH >= 2 and NUM_STAGES >= MIN_SYNC_STAGES");
    end

    logic [NUM_STAGES-1:0][BUS_WIDTH-1:0] stage_r;
    logic [BUS_WIDTH-1:0]                 bin_comb_s;
    logic [BUS_WIDTH-1:0]                 bin_src_s;
    logic [BUS_WIDTH-1:0]                 prev_r;
    logic                                 changed_r;
    logic [BUS_WIDTH-1:0]                 delta_r;

    // Synchroniser chain: pure flop-to-flop, stage 0 captures the async input.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            stage_r <= '0;
        end else begin
            stage_r <= {stage_r[NUM_STAGES-2:0], unsync_gray};
        end
    end

    assign sync_gray = stage_r[NUM_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_conv
        assign bin_comb_s[i] = ^stage_r[NUM_STAGES-1][BUS_WIDTH-1:i];
    end

`ifdef PTR_SYNC_BIN_REG_EN
    logic [BUS_WIDTH-1:0] bin_r;

    // Retiming flop that breaks the XOR prefix away from the change/delta logic.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bin_r <= '0;
        end else begin
            bin_r <= bin_comb_s;
        end
    end

    assign bin_src_s = bin_r;
`else
    assign bin_src_s = bin_comb_s;
`endif

    assign sync_bin = bin_src_s;

    // Modular subtraction makes wrap-around and multi-count jumps report the true distance.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_r    <= '0;
            changed_r <= 1'b0;
            delta_r   <= '0;
        end else begin
            prev_r    <= bin_src_s;
            changed_r <= (bin_src_s != prev_r);
            delta_r   <= bin_src_s - prev_r;
        end
    end

    assign changed = changed_r;
    assign delta   = delta_r;

endmodule

// File: rtl/ptr_sync_multi.sv
// Multi-channel Gray pointer synchroniser; NUM_CH independent ptr_sync_ch slices.
// PTR_SYNC_BIN_REG_EN (see ptr_sync_ch) registers sync_bin for timing at wide BUS_WIDTH.
module ptr_sync_multi
    import ptr_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_gray,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_gray,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bin,
    output logic [NUM_CH-1:0]           changed,
    output logic [NUM_CH*BUS_WIDTH-1:0] delta
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ptr_sync_ch #(
            .BUS_WIDTH  (BUS_WIDTH),
            .NUM_STAGES (NUM_STAGES)
        ) u_ch (
            .CLK         (CLK),
            .RST         (RST),
            .unsync_gray (unsync_gray[c*BUS_WIDTH +: BUS_WIDTH]),
            .sync_gray   (sync_gray[c*BUS_WIDTH +: BUS_WIDTH]),
            .sync_bin    (sync_bin[c*BUS_WIDTH +: BUS_WIDTH]),
            .changed     (changed[c]),
            .delta       (delta[c*BUS_WIDTH +: BUS_WIDTH])
        );
    end

endmodule

// File: tb/tb_ptr_sync_multi.sv
// Scoreboard bench for ptr_sync_multi (W=4, 2 stages, 2 channels): directed scenarios then random walks.
// The model works on the per-cycle history of binary pointer values and pure latency arithmetic.
module tb_ptr_sync_multi;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CH = 2;
`ifdef PTR_SYNC_BIN_REG_EN
    localparam int X = 1;
`else
    localparam int X = 0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [CH*W-1:0] unsync_gray = '0;
    logic [CH*W-1:0] sync_gray;
    logic [CH*W-1:0] sync_bin;
    logic [CH-1:0]   changed;
    logic [CH*W-1:0] delta;

    ptr_sync_multi #(.BUS_WIDTH(W), .NUM_STAGES(S), .NUM_CH(CH)) dut (
        .CLK(CLK), .RST(RST), .unsync_gray(unsync_gray), .sync_gray(sync_gray),
        .sync_bin(sync_bin), .changed(changed), .delta(delta)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [CH*W-1:0] g;
        logic [CH*W-1:0] b;
        logic [CH-1:0]   c;
        logic [CH*W-1:0] d;
    } exp_t;

    exp_t       sbq[$];
    logic [W-1:0] hist0[$];
    logic [W-1:0] hist1[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary value applied to a channel before edge idx since reset release; 0 before the first edge.
    function automatic logic [W-1:0] h(input int ch, input int idx);
        if (idx < 0) return '0;
        return (ch == 0) ? hist0[idx] : hist1[idx];
    endfunction

    task automatic check(input string name, input logic [CH*W-1:0] act, input logic [CH*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle (inputs given in binary) and queue the response expected after the next edge.
    task automatic drive(input logic rst_v, input logic [W-1:0] b0, input logic [W-1:0] b1);
        exp_t e;
        int   n, ci;
        logic [W-1:0] cur, prv;
        @(negedge CLK);
        unsync_gray = {to_gray(b1), to_gray(b0)};
        if (!rst_v) begin
            if (RST) begin
                RST = 1'b0;
                #1;
                check("async_rst_gray", sync_gray, '0);
                check("async_rst_bin", sync_bin, '0);
                check("async_rst_chg", {{(CH*W-CH){1'b0}}, changed}, '0);
                check("async_rst_delta", delta, '0);
            end
            hist0.delete();
            hist1.delete();
            e.g = '0; e.b = '0; e.c = '0; e.d = '0;
        end else begin
            RST = 1'b1;
            hist0.push_back(b0);
            hist1.push_back(b1);
            n  = hist0.size() - 1;
            ci = n - S - X;
            for (int c = 0; c < CH; c++) begin
                e.g[c*W +: W] = to_gray(h(c, n - (S - 1)));
                e.b[c*W +: W] = h(c, n - (S - 1) - X);
                cur = h(c, ci);
                prv = h(c, ci - 1);
                e.c[c]        = (cur != prv);
                e.d[c*W +: W] = cur - prv;
            end
        end
        sbq.push_back(e);
    endtask

    // Monitor: the DUT presents a result every cycle; compare it just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sync_gray", sync_gray, e.g);
                check("sync_bin", sync_bin, e.b);
                check("changed", {{(CH*W-CH){1'b0}}, changed}, {{(CH*W-CH){1'b0}}, e.c});
                check("delta", delta, e.d);
            end
        end
    end

    initial begin
        logic [W-1:0] b0, b1;
        // Scenario 1: reset with gray FF (bin A) on both channels, then release.
        repeat (3) drive(1'b0, 4'hA, 4'hA);
        repeat (5) drive(1'b1, 4'hA, 4'hA);
        repeat (2) drive(1'b0, 4'h0, 4'h0);
        repeat (4) drive(1'b1, 4'h0, 4'h0);
        // Scenario 2: ch0 +1.
        repeat (5) drive(1'b1, 4'h1, 4'h0);
        // Scenario 3: ch0 multi-count jump bin 1 -> 4.
        repeat (5) drive(1'b1, 4'h4, 4'h0);
        // Scenario 4: ch1 walks to 15 then wraps to 0.
        for (int i = 1; i < 16; i++) drive(1'b1, 4'h4, 4'(i));
        repeat (5) drive(1'b1, 4'h4, 4'h0);
        // Scenario 5: simultaneous ch0 +1, ch1 +2.
        repeat (5) drive(1'b1, 4'h5, 4'h2);
        // Scenario 6: reset while a ch0 change is mid-chain; input held at gray 0110.
        drive(1'b1, 4'h7, 4'h2);
        repeat (2) drive(1'b0, 4'h4, 4'h0);
        repeat (6) drive(1'b1, 4'h4, 4'h0);
        // Random walks with occasional jumps, wraps and resets.
        b0 = 4'h4;
        b1 = 4'h0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                drive(1'b0, b0, b1);
            end else begin
                if ($urandom_range(0, 2) == 0) b0 = b0 + 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) b1 = b1 + 4'($urandom_range(0, 15));
                drive(1'b1, b0, b1);
            end
        end
        repeat (2) @(posedge CLK);
        #2;
        check("scoreboard_drained", CH*W'(sbq.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
